// File: rtl/cart_responder.sv
// Game Boy cartridge bus responder: serves ROM/SRAM images from block RAM with MBC1 banking.
// Define CART_MBC1_EN for full MBC1 banking; leave it undefined for a plain ROM-only cart.
module cart_responder #(
    parameter int ROM_AW      = 21,
    parameter int RAM_AW      = 15,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clock,
    input  logic              reset_l,
    input  logic [15:0]       gb_addr,
    input  logic [7:0]        gb_din,
    input  logic              gb_rd_l,
    input  logic              gb_wr_l,
    input  logic              gb_cs_l,
    output logic [7:0]        gb_dout,
    output logic              gb_doe,
    output logic [ROM_AW-1:0] rom_addr,
    output logic              rom_en,
    input  logic [7:0]        rom_q,
    output logic [RAM_AW-1:0] ram_addr,
    output logic              ram_en,
    output logic              ram_we,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_q
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] FETCH = 3'd1;
    localparam logic [2:0] WAIT  = 3'd2;
    localparam logic [2:0] DRIVE = 3'd3;
    localparam logic [2:0] WRITE = 3'd4;
    localparam logic [2:0] HOLD  = 3'd5;

    localparam logic [1:0] SRC_ROM = 2'd0;
    localparam logic [1:0] SRC_RAM = 2'd1;
    localparam logic [1:0] SRC_FF  = 2'd2;

    logic [23:0] data_sync [SYNC_STAGES];
    logic [2:0]  strb_sync [SYNC_STAGES];
    logic [15:0] addr_s;
    logic [7:0]  din_s;
    logic        rd_s;
    logic        wr_s;
    logic        cs_s;
    logic        rd_d;
    logic        wr_d;
    logic        rd_fall;
    logic        wr_fall;

    logic [2:0]  state;
    logic [1:0]  src;
    logic        is_rom;
    logic        ram_hit;
    logic        ram_on;
    logic [ROM_AW-1:0] rom_next;
    logic [RAM_AW-1:0] ram_next;

    // Bus synchronisers: address/data need no reset, strobes reset to idle-high
    always_ff @(posedge clock) begin
        data_sync[0] <= {gb_addr, gb_din};
        for (int i = 1; i < SYNC_STAGES; i++) begin
            data_sync[i] <= data_sync[i-1];
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_l) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                strb_sync[i] <= 3'b111;
            end
            rd_d <= 1'b1;
            wr_d <= 1'b1;
        end else begin
            strb_sync[0] <= {gb_rd_l, gb_wr_l, gb_cs_l};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                strb_sync[i] <= strb_sync[i-1];
            end
            rd_d <= rd_s;
            wr_d <= wr_s;
        end
    end

    assign addr_s  = data_sync[SYNC_STAGES-1][23:8];
    assign din_s   = data_sync[SYNC_STAGES-1][7:0];
    assign rd_s    = strb_sync[SYNC_STAGES-1][2];
    assign wr_s    = strb_sync[SYNC_STAGES-1][1];
    assign cs_s    = strb_sync[SYNC_STAGES-1][0];
    assign rd_fall = rd_d & ~rd_s;
    assign wr_fall = wr_d & ~wr_s;

    assign is_rom  = ~addr_s[15];
    assign ram_hit = (addr_s[15:13] == 3'b101) && !cs_s && ram_on;

`ifdef CART_MBC1_EN
    logic       ram_enable;
    logic [4:0] bank_lo;
    logic [1:0] bank_hi;
    logic       mode;
    logic [6:0] rom_bank;

    always_ff @(posedge clock) begin
        if (!reset_l) begin
            ram_enable <= 1'b0;
            bank_lo    <= 5'd1;
            bank_hi    <= 2'd0;
            mode       <= 1'b0;
        end else if (state == WRITE && !addr_s[15]) begin
            case (addr_s[14:13])
                2'd0:    ram_enable <= (din_s[3:0] == 4'hA);
                2'd1:    bank_lo    <= (din_s[4:0] == 5'd0) ? 5'd1 : din_s[4:0];
                2'd2:    bank_hi    <= din_s[1:0];
                default: mode       <= din_s[0];
            endcase
        end
    end

    always_comb begin
        rom_bank = 7'd0;
        if (addr_s[14]) begin
            rom_bank = {bank_hi, bank_lo};
        end else if (mode) begin
            rom_bank = {bank_hi, 5'd0};
        end
    end

    // Banks beyond the image size wrap silently through the width cast
    assign ram_on   = ram_enable;
    assign rom_next = ROM_AW'({rom_bank, addr_s[13:0]});
    assign ram_next = RAM_AW'({(mode ? bank_hi : 2'b00), addr_s[12:0]});
`else
    assign ram_on   = 1'b1;
    assign rom_next = ROM_AW'(addr_s[14:0]);
    assign ram_next = RAM_AW'(addr_s[12:0]);
`endif

    always_ff @(posedge clock) begin
        if (!reset_l) begin
            state    <= IDLE;
            src      <= SRC_FF;
            gb_doe   <= 1'b0;
            gb_dout  <= 8'h00;
            rom_addr <= '0;
            ram_addr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rd_fall && wr_s) begin
                        state    <= FETCH;
                        rom_addr <= rom_next;
                        ram_addr <= ram_next;
                    end else if (wr_fall && rd_s) begin
                        state    <= WRITE;
                        ram_addr <= ram_next;
                    end
                end
                FETCH: begin
                    src   <= is_rom ? SRC_ROM : (ram_hit ? SRC_RAM : SRC_FF);
                    state <= WAIT;
                end
                WAIT: begin
                    case (src)
                        SRC_ROM: gb_dout <= rom_q;
                        SRC_RAM: gb_dout <= ram_q;
                        default: gb_dout <= 8'hFF;
                    endcase
                    gb_doe <= 1'b1;
                    state  <= DRIVE;
                end
                DRIVE: begin
                    if (rd_s) begin
                        gb_doe <= 1'b0;
                        state  <= IDLE;
                    end
                end
                WRITE: state <= HOLD;
                HOLD: begin
                    if (wr_s) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Strobes are single-cycle by construction: FETCH and WRITE each last one clock
    assign rom_en    = (state == FETCH) && is_rom;
    assign ram_en    = ((state == FETCH) || (state == WRITE)) && ram_hit;
    assign ram_we    = (state == WRITE) && ram_hit;
    assign ram_wdata = din_s;

endmodule

// File: tb/tb_cart_responder.sv
// Directed bench for cart_responder: vector table of bus reads/writes plus corner sequences.
module tb_cart_responder;

`ifdef CART_MBC1_EN
    localparam bit MBC = 1'b1;
`else
    localparam bit MBC = 1'b0;
`endif

    logic        clock;
    logic        reset_l;
    logic [15:0] gb_addr;
    logic [7:0]  gb_din;
    logic        gb_rd_l;
    logic        gb_wr_l;
    logic        gb_cs_l;
    logic [7:0]  gb_dout;
    logic        gb_doe;
    logic [20:0] rom_addr;
    logic        rom_en;
    logic [7:0]  rom_q;
    logic [14:0] ram_addr;
    logic        ram_en;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_q;

    int checks;
    int errors;

    cart_responder #(.ROM_AW(21), .RAM_AW(15), .SYNC_STAGES(2)) dut (
        .clock(clock), .reset_l(reset_l), .gb_addr(gb_addr), .gb_din(gb_din),
        .gb_rd_l(gb_rd_l), .gb_wr_l(gb_wr_l), .gb_cs_l(gb_cs_l),
        .gb_dout(gb_dout), .gb_doe(gb_doe), .rom_addr(rom_addr), .rom_en(rom_en),
        .rom_q(rom_q), .ram_addr(ram_addr), .ram_en(ram_en), .ram_we(ram_we),
        .ram_wdata(ram_wdata), .ram_q(ram_q)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ROM image returns the low address byte; SRAM image starts as addr[7:0]^A5
    logic [7:0] mem [32768];
    bit         mem_init;
    always @(posedge clock) begin
        if (rom_en) rom_q <= rom_addr[7:0];
    end
    always @(posedge clock) begin
        if (!mem_init) begin
            for (int i = 0; i < 32768; i++) mem[i] <= 8'(i) ^ 8'hA5;
            mem_init <= 1'b1;
        end else if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            ram_q <= mem[ram_addr];
        end
    end

    int          rom_cnt, ram_en_cnt, ram_we_cnt, doe_cnt;
    logic [20:0] last_rom_addr;
    logic [14:0] last_ram_addr;
    logic [7:0]  last_wdata;
    always @(posedge clock) begin
        if (rom_en) begin
            rom_cnt       <= rom_cnt + 1;
            last_rom_addr <= rom_addr;
        end
        if (ram_en) begin
            ram_en_cnt    <= ram_en_cnt + 1;
            last_ram_addr <= ram_addr;
        end
        if (ram_we) begin
            ram_we_cnt <= ram_we_cnt + 1;
            last_wdata <= ram_wdata;
        end
        if (gb_doe) doe_cnt <= doe_cnt + 1;
    end

    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [7:0]  data;
        logic        cs;
        logic [7:0]  exp_d;
        int          exp_rom;
        logic [20:0] exp_rom_addr;
        int          exp_ram;
        int          exp_we;
        logic [14:0] exp_ram_addr;
    } vec_t;
    vec_t vq[$];

    task automatic add(input bit w, input logic [15:0] a, input logic [7:0] d, input logic cs,
                       input logic [7:0] ed, input int er, input logic [20:0] era,
                       input int em, input int ewe, input logic [14:0] ema);
        vec_t v;
        v.wr = w; v.addr = a; v.data = d; v.cs = cs; v.exp_d = ed; v.exp_rom = er;
        v.exp_rom_addr = era; v.exp_ram = em; v.exp_we = ewe; v.exp_ram_addr = ema;
        vq.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic do_read(input logic [15:0] a, input logic cs, output logic [7:0] d,
                           output int lat, output bit held, output bit released,
                           output int drom, output int dram);
        int r0, m0;
        r0 = rom_cnt; m0 = ram_en_cnt;
        lat = 0; held = 1'b0; released = 1'b0; d = 8'h00;
        @(negedge clock);
        gb_addr = a; gb_cs_l = cs;
        @(negedge clock);
        gb_rd_l = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clock);
            if (gb_doe) begin
                lat = i;
                break;
            end
        end
        d = gb_dout;
        repeat (3) @(negedge clock);
        held = gb_doe;
        gb_rd_l = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (!gb_doe) begin
                released = 1'b1;
                break;
            end
        end
        gb_cs_l = 1'b1;
        repeat (2) @(negedge clock);
        drom = rom_cnt - r0;
        dram = ram_en_cnt - m0;
    endtask

    task automatic do_write(input logic [15:0] a, input logic [7:0] d, input logic cs,
                            input int hold, output int dwe, output int den);
        int w0, m0;
        w0 = ram_we_cnt; m0 = ram_en_cnt;
        @(negedge clock);
        gb_addr = a; gb_din = d; gb_cs_l = cs;
        @(negedge clock);
        gb_wr_l = 1'b0;
        repeat (hold) @(negedge clock);
        gb_wr_l = 1'b1;
        repeat (6) @(negedge clock);
        gb_cs_l = 1'b1;
        dwe = ram_we_cnt - w0;
        den = ram_en_cnt - m0;
    endtask

    initial begin
        logic [7:0] d;
        int lat, drom, dram, dwe, den, s0, s1, s2;
        bit held, released, got_doe;
        checks = 0; errors = 0;
        rom_cnt = 0; ram_en_cnt = 0; ram_we_cnt = 0; doe_cnt = 0;
        reset_l = 1'b0; gb_addr = 16'h0000; gb_din = 8'h00;
        gb_rd_l = 1'b1; gb_wr_l = 1'b1; gb_cs_l = 1'b1;

        add(0, 16'h0150, 8'h00, 1, 8'h50, 1, 21'h00150, 0, 0, 15'h0);
        add(1, 16'h2000, 8'h00, 1, 8'h00, 0, 21'h0, 0, 0, 15'h0);
        add(0, 16'h4000, 8'h00, 1, 8'h00, 1, 21'h04000, 0, 0, 15'h0);
        add(1, 16'h2000, 8'h05, 1, 8'h00, 0, 21'h0, 0, 0, 15'h0);
        add(0, 16'h7FFF, 8'h00, 1, 8'hFF, 1, MBC ? 21'h17FFF : 21'h07FFF, 0, 0, 15'h0);
        add(0, 16'hA000, 8'h00, 0, MBC ? 8'hFF : 8'hA5, 0, 21'h0, MBC ? 0 : 1, 0, 15'h0000);
        add(1, 16'h0000, 8'h0A, 1, 8'h00, 0, 21'h0, 0, 0, 15'h0);
        add(1, 16'hA123, 8'h5C, 0, 8'h00, 0, 21'h0, 1, 1, 15'h0123);
        add(0, 16'hA123, 8'h00, 0, 8'h5C, 0, 21'h0, 1, 0, 15'h0123);
        add(1, 16'h4000, 8'h02, 1, 8'h00, 0, 21'h0, 0, 0, 15'h0);
        add(1, 16'h6000, 8'h01, 1, 8'h00, 0, 21'h0, 0, 0, 15'h0);
        add(0, 16'h0000, 8'h00, 1, 8'h00, 1, MBC ? 21'h100000 : 21'h00000, 0, 0, 15'h0);
        add(0, 16'hA123, 8'h00, 0, MBC ? 8'h86 : 8'h5C, 0, 21'h0, 1, 0, MBC ? 15'h4123 : 15'h0123);
        add(0, 16'h8000, 8'h00, 1, 8'hFF, 0, 21'h0, 0, 0, 15'h0);
        add(0, 16'hA000, 8'h00, 1, 8'hFF, 0, 21'h0, 0, 0, 15'h0);
        add(1, 16'h2000, 8'h1F, 1, 8'h00, 0, 21'h0, 0, 0, 15'h0);
        add(0, 16'h4000, 8'h00, 1, 8'h00, 1, MBC ? 21'h17C000 : 21'h04000, 0, 0, 15'h0);

        repeat (5) @(negedge clock);
        chk("rst_doe", 32'(gb_doe), 32'd0);
        chk("rst_dout", 32'(gb_dout), 32'h00);
        chk("rst_rom_en", 32'(rom_en), 32'd0);
        chk("rst_ram_en", 32'(ram_en), 32'd0);
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        chk("rst_rom_addr", 32'(rom_addr), 32'h0);
        chk("rst_ram_addr", 32'(ram_addr), 32'h0);
        reset_l = 1'b1;
        repeat (3) @(negedge clock);

        foreach (vq[k]) begin
            if (vq[k].wr) begin
                do_write(vq[k].addr, vq[k].data, vq[k].cs, 4, dwe, den);
                chk($sformatf("v%0d_we_cnt", k), 32'(dwe), 32'(vq[k].exp_we));
                chk($sformatf("v%0d_ram_en_cnt", k), 32'(den), 32'(vq[k].exp_ram));
                if (vq[k].exp_we > 0) begin
                    chk($sformatf("v%0d_ram_addr", k), 32'(last_ram_addr), 32'(vq[k].exp_ram_addr));
                    chk($sformatf("v%0d_wdata", k), 32'(last_wdata), 32'(vq[k].data));
                end
            end else begin
                do_read(vq[k].addr, vq[k].cs, d, lat, held, released, drom, dram);
                chk($sformatf("v%0d_latency", k), 32'(lat), 32'd5);
                chk($sformatf("v%0d_data", k), 32'(d), 32'(vq[k].exp_d));
                chk($sformatf("v%0d_doe_held", k), 32'(held), 32'd1);
                chk($sformatf("v%0d_doe_release", k), 32'(released), 32'd1);
                chk($sformatf("v%0d_rom_cnt", k), 32'(drom), 32'(vq[k].exp_rom));
                chk($sformatf("v%0d_ram_cnt", k), 32'(dram), 32'(vq[k].exp_ram));
                if (vq[k].exp_rom > 0)
                    chk($sformatf("v%0d_rom_addr", k), 32'(last_rom_addr), 32'(vq[k].exp_rom_addr));
                if (vq[k].exp_ram > 0)
                    chk($sformatf("v%0d_ram_addr", k), 32'(last_ram_addr), 32'(vq[k].exp_ram_addr));
            end
        end

        // rd and wr asserted together: no access at all
        s0 = rom_cnt + ram_en_cnt; s1 = ram_we_cnt; s2 = doe_cnt;
        @(negedge clock);
        gb_addr = 16'hA123; gb_cs_l = 1'b0;
        @(negedge clock);
        gb_rd_l = 1'b0; gb_wr_l = 1'b0;
        repeat (12) @(negedge clock);
        gb_rd_l = 1'b1; gb_wr_l = 1'b1;
        repeat (6) @(negedge clock);
        gb_cs_l = 1'b1;
        chk("both_low_strobes", 32'(rom_cnt + ram_en_cnt - s0), 32'd0);
        chk("both_low_we", 32'(ram_we_cnt - s1), 32'd0);
        chk("both_low_doe", 32'(doe_cnt - s2), 32'd0);

        // long write strobe: exactly one SRAM write
        do_write(16'hA050, 8'h77, 1'b0, 50, dwe, den);
        chk("long_wr_we_cnt", 32'(dwe), 32'd1);
        chk("long_wr_addr", 32'(last_ram_addr), MBC ? 32'h4050 : 32'h0050);
        do_read(16'hA050, 1'b0, d, lat, held, released, drom, dram);
        chk("long_wr_readback", 32'(d), 32'h77);

        // reset while driving the bus
        @(negedge clock);
        gb_addr = 16'h0150; gb_cs_l = 1'b1;
        @(negedge clock);
        gb_rd_l = 1'b0;
        got_doe = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (gb_doe) begin
                got_doe = 1'b1;
                break;
            end
        end
        chk("drive_reached", 32'(got_doe), 32'd1);
        reset_l = 1'b0;
        @(posedge clock);
        #1;
        chk("mid_rst_doe", 32'(gb_doe), 32'd0);
        chk("mid_rst_dout", 32'(gb_dout), 32'h00);
        @(negedge clock);
        gb_rd_l = 1'b1;
        repeat (4) @(negedge clock);
        reset_l = 1'b1;
        repeat (3) @(negedge clock);

        do_read(16'h4000, 1'b1, d, lat, held, released, drom, dram);
        chk("post_rst_bank_rom_addr", 32'(last_rom_addr), 32'h04000);
        chk("post_rst_bank_rom_cnt", 32'(drom), 32'd1);
        do_read(16'h0000, 1'b1, d, lat, held, released, drom, dram);
        chk("post_rst_mode_rom_addr", 32'(last_rom_addr), 32'h00000);
        do_read(16'hA000, 1'b0, d, lat, held, released, drom, dram);
        chk("post_rst_ram_data", 32'(d), MBC ? 32'hFF : 32'hA5);
        chk("post_rst_ram_cnt", 32'(dram), MBC ? 32'd0 : 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
